// File: rtl/hilo_multdiv.sv
// HI/LO multiply-divide unit: 32-cycle iterative shift-add multiply and restoring divide.
// Signed operations work on magnitudes; signs are applied once, at the final update.
module hilo_multdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mcand;
    logic [63:0] r_prod;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;

    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_sh;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_next;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_sgn   = ~op[0];
    assign w_a_neg = w_sgn & operand_a[31];
    assign w_b_neg = w_sgn & operand_b[31];

    // Multiply: r_prod = {partial, multiplier}, add multiplicand into the top when LSB set.
    assign w_mul_sum  = {1'b0, r_prod[63:32]} + {1'b0, r_mcand};
    assign w_mul_next = r_prod[0] ? {w_mul_sum, r_prod[31:1]} : {1'b0, r_prod[63:1]};

    // Divide: r_prod = {remainder, dividend/quotient}; quotient bits shift in at the bottom.
    assign w_div_sh   = r_prod[63:31];
    assign w_div_diff = w_div_sh - {1'b0, r_mcand};
    assign w_div_next = w_div_diff[32] ? {w_div_sh[31:0], r_prod[30:0], 1'b0}
                                       : {w_div_diff[31:0], r_prod[30:0], 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_mcand <= mag32(operand_a, w_a_neg);
                                r_prod  <= {32'd0, mag32(operand_b, w_b_neg)};
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_cnt   <= 5'd0;
                                r_busy  <= 1'b1;
                                r_state <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_mcand <= mag32(operand_b, w_b_neg);
                                r_prod  <= {32'd0, mag32(operand_a, w_a_neg)};
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                                r_dz    <= (operand_b == 32'd0);
                                r_cnt   <= 5'd0;
                                r_busy  <= 1'b1;
                                r_state <= S_DIV;
                            end
                            OP_MTHI: r_hi <= operand_a;
                            OP_MTLO: r_lo <= operand_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        {r_hi, r_lo} <= neg64(w_mul_next, r_neg_q);
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_prod <= w_mul_next;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        // Divide-by-zero leaves remainder = |a|, so only the quotient is forced.
                        r_lo    <= r_dz ? 32'hFFFF_FFFF : mag32(w_div_next[31:0], r_neg_q);
                        r_hi    <= mag32(w_div_next[63:32], r_neg_r);
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_prod <= w_div_next;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/hilo_multdiv.md
HILO_MULTDIV -- requirements
Module: hilo_multdiv

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and 32-bit HI/LO.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 op_valid  input  1  operation request this cycle.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 operand_a  input  32  rs read data from register file (dividend / multiplicand / MTHI-MTLO source).
REQ-008 operand_b  input  32  rt read data from register file (divisor / multiplier).
REQ-009 busy  output  1  multi-cycle operation in progress; pipeline stalls any HI/LO access while high.
REQ-010 hi  output  32  HI register, driven directly from flop.
REQ-011 lo  output  32  LO register, driven directly from flop.

Function
REQ-012 The block SHALL accept a request on a posedge where op_valid=1, busy=0 and reset=0; all other requests SHALL be ignored with no state change.
REQ-013 Reserved op codes 110/111 SHALL be ignored: no busy assertion and no HI/LO change.
REQ-014 MTHI SHALL write operand_a to hi at the accepting edge; MTLO SHALL write operand_a to lo at the accepting edge; busy SHALL stay 0.
REQ-015 The FSM SHALL have states IDLE, MUL and DIV, plus a 5-bit iteration counter.
REQ-016 IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU; operands and signedness SHALL be latched at that edge.
REQ-017 MUL and DIV SHALL each last exactly 32 cycles: busy=1 from the cycle after the accepting edge E0 through the cycle ending at edge E32.
REQ-018 At edge E32 the FSM SHALL return to IDLE, busy SHALL fall, and hi/lo SHALL be written with the result in a single update.
REQ-019 hi/lo SHALL hold their pre-operation values throughout busy; no partial results SHALL be visible.
REQ-020 MULTU SHALL compute the unsigned 64-bit product; hi = bits 63:32, lo = bits 31:0.
REQ-021 MULT SHALL compute the two's-complement 64-bit product of signed operands, split as for MULTU.
REQ-022 DIVU SHALL compute lo = unsigned quotient and hi = unsigned remainder using restoring division, one quotient bit per cycle.
REQ-023 DIV SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend, satisfying a = q*b + r.
REQ-024 For DIV/DIVU with operand_b=0, the result SHALL be lo=0xFFFFFFFF and hi=operand_a, with full 32-cycle latency.
REQ-025 For DIV with 0x80000000 / 0xFFFFFFFF, the result SHALL be lo=0x80000000 and hi=0x00000000.
REQ-026 Back-to-back operation: a request presented in the cycle after E32 (busy=0) SHALL be accepted normally.
REQ-027 Arithmetic SHALL be iterative, one shift-add or shift-subtract step per cycle; no full-width combinational multiplier or divider SHALL be used.

Reset
REQ-028 While reset=1 at a posedge, the block SHALL set hi=0, lo=0 and busy=0, enter IDLE and clear the counter, regardless of op_valid.
REQ-029 Reset during MUL or DIV SHALL abort the operation; no result SHALL be written after reset deasserts.

Verification
REQ-030 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for exactly 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT a=0xFFFFFFFD (-3) b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIVU a=7 b=2 -> lo=3, hi=1.
REQ-032 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIV a=0x12345678 b=0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x12345678.
REQ-034 MTHI 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy stays 0; MTLO 0x1 issued during busy -> ignored, lo unchanged at completion except by the result.
REQ-035 reset=1 at busy cycle 10 of MULTU -> next cycle busy=0, hi=lo=0, and no later write occurs; a following DIVU 9/4 -> lo=2, hi=1.
